// File: rtl/int_pkg.sv
// Shared constants for the interrupt pending front-end: source count,
// source bit positions and the request/ack handshake state encoding.
package int_pkg;

    localparam int unsigned NUM_SRC = 4;

    // Bit position of each device in the source vectors (SRC4 is highest priority).
    localparam int unsigned SRC1 = 0;
    localparam int unsigned SRC2 = 1;
    localparam int unsigned SRC3 = 2;
    localparam int unsigned SRC4 = 3;

    // Handshake states: idle, requesting, acknowledged (grant frozen), clearing.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StAck  = 2'd2,
        StClr  = 2'd3
    } state_e;

endpackage

// File: rtl/int_prio_onehot.sv
// Fixed-priority selector: returns the highest set request bit as a one-hot
// vector, or zero when no request is set.
module int_prio_onehot
    import int_pkg::*;
(
    input  logic [NUM_SRC-1:0] req_i,
    output logic [NUM_SRC-1:0] gnt_o
);

    // Walk from the highest-priority source downward.
    always_comb begin
        gnt_o = '0;
        if (req_i[SRC4]) begin
            gnt_o[SRC4] = 1'b1;
        end else if (req_i[SRC3]) begin
            gnt_o[SRC3] = 1'b1;
        end else if (req_i[SRC2]) begin
            gnt_o[SRC2] = 1'b1;
        end else if (req_i[SRC1]) begin
            gnt_o[SRC1] = 1'b1;
        end
    end

endmodule

// File: rtl/int_pending_ctrl.sv
// Interrupt front-end: captures device done rises into sticky pending bits,
// masks them, requests the CPU and holds a frozen one-hot grant during ack.
module int_pending_ctrl #(
    parameter int unsigned         NUM_SRC = 4,
    parameter logic [NUM_SRC-1:0] EN_RST  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] dev_done,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wd,
    input  logic               int_ack,
    output logic               int_req,
    output logic               done1,
    output logic               done2,
    output logic               done3,
    output logic               done4,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] int_en
);
    import int_pkg::*;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] dev_prev_q;
    logic [NUM_SRC-1:0] int_en_q, int_en_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] prio_sel;
    logic [NUM_SRC-1:0] done_vec;
    logic               take_ack;

    assign rise     = dev_done & ~dev_prev_q;
    assign act      = pending_q & int_en_q;
    assign take_ack = (state_q == StReq) && int_ack && (act != '0);

    int_prio_onehot u_prio (
        .req_i (act),
        .gnt_o (prio_sel)
    );

    // Pending/enable/grant next state; a fresh rise beats the CLR-cycle clear.
    always_comb begin
        clr_mask  = (state_q == StClr) ? grant_q : '0;
        pending_d = (pending_q & ~clr_mask) | rise;
        int_en_d  = en_we ? en_wd : int_en_q;
        grant_d   = take_ack ? prio_sel : grant_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            dev_prev_q <= '0;
            int_en_q   <= EN_RST;
            grant_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            dev_prev_q <= dev_done;
            int_en_q   <= int_en_d;
            grant_q    <= grant_d;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; losing all active sources in REQ takes priority over ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (act != '0) state_d = StReq;
            StReq: begin
                if (act == '0) begin
                    state_d = StIdle;
                end else if (int_ack) begin
                    state_d = StAck;
                end
            end
            StAck:   if (!int_ack) state_d = StClr;
            StClr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registers only: live active set in REQ, frozen grant in ACK.
    always_comb begin
        int_req  = 1'b0;
        done_vec = '0;
        unique case (state_q)
            StReq: begin
                int_req  = 1'b1;
                done_vec = act;
            end
            StAck:   done_vec = grant_q;
            default: ;
        endcase
    end

    assign done1   = done_vec[SRC1];
    assign done2   = done_vec[SRC2];
    assign done3   = done_vec[SRC3];
    assign done4   = done_vec[SRC4];
    assign pending = pending_q;
    assign int_en  = int_en_q;

endmodule

// File: doc/int_pending_ctrl.md
# int_pending_ctrl

Interrupt request front-end sitting directly upstream of the vectored interrupt controller. It captures rising edges on four device done lines into sticky pending bits, applies a software-writable enable mask, and raises a request to the CPU. During the CPU acknowledge it holds a stable one-hot grant on `done1..done4`, so the downstream vector address cannot change mid-ack. When the acknowledge ends it clears the serviced pending bit.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of interrupt sources. Only 4 is supported, because the downstream block has four inputs.
- `EN_RST`, default 4'b0000: reset value of the enable mask.

Ports:
- `clk`  input  1  single system clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `dev_done`  input  4  level done flags from devices; bit 0 is device 1 (lowest priority), bit 3 is device 4 (highest).
- `en_we`  input  1  write strobe for the enable mask.
- `en_wd`  input  4  enable mask write data.
- `int_ack`  input  1  CPU acknowledge level, synchronous to `clk`.
- `int_req`  output  1  interrupt request to the CPU.
- `done1`, `done2`, `done3`, `done4`  output  1 each  request lines to the vectored interrupt controller.
- `pending`  output  4  raw pending bits, for status readback.
- `int_en`  output  4  current enable mask.

## Operation
- **Edge capture:** `dev_prev` registers `dev_done`. A rise is `dev_done & ~dev_prev`; each rise sets the corresponding `pending` bit. A level held high sets the bit only once.
- **Active set:** `act = pending & int_en`.
- **Enable mask:**
  - `int_en` loads `en_wd` on `en_we`.
  - Masking a source does not clear its pending bit.
  - Re-enabling a still-pending source makes it eligible again.
- **FSM state IDLE:**
  - `int_req=0`; the `done` outputs are all 0.
  - Go to REQ when `act != 0`.
- **FSM state REQ:**
  - `int_req=1`; `{done4..done1} = act`, tracking live.
  - `act` becoming 0 (masked) → IDLE.
  - `int_ack=1` → ACK. On that edge, latch `grant` = highest-priority set bit of `act`, as a one-hot value.
- **FSM state ACK:**
  - `int_req=0`; `{done4..done1} = grant`, frozen.
  - Changes to `int_en` or `pending` do not affect the outputs in this state.
  - `int_ack=0` → CLR.
- **FSM state CLR (one cycle):**
  - Clear the `grant` bit from `pending`; outputs all 0; `int_req=0`.
  - Unconditionally → IDLE.
- **Simultaneous set and clear:** a new rise on the bit being cleared in CLR wins. The bit stays pending.
- **Spurious ack:** `int_ack=1` in IDLE is ignored; nothing is latched or cleared.
- **Reset:** `rst` at any time, including mid-ACK, forces:
  - state = IDLE, `pending=0`, `dev_prev=0`, `grant=0`, `int_en=EN_RST`;
  - all outputs 0, except `int_en`, which shows `EN_RST`.

## Timing
- All outputs are registered, or are decoded purely from registered state and registers; there is no combinational path from any input to any output.
- **Rise to pending:** rise sampled at edge E0 → `pending` bit visible after E0.
- **Request latency:** 2 cycles from the sampling edge to `int_req` (E0: pending set; E1: state → REQ).
- **Ack entry:** `int_ack` sampled high at edge A → `done` lines hold one-hot `grant` from A+1 until the edge on which `int_ack` is sampled low.
- **Ack exit:** `int_ack` sampled low at edge D → CLR; pending bit cleared at D+1; earliest re-request at D+2, since evaluation happens in IDLE.
- **Mask write:** `en_we` takes effect on the same edge it is sampled.

## Structure
- **Shared package (`int_pkg`):**
  - state encoding constants IDLE / REQ / ACK / CLR (2-bit);
  - `NUM_SRC`;
  - source index constants `SRC1`..`SRC4`.
- **Sub-module `int_prio_onehot`:** combinational 4-bit priority-to-one-hot selector (bit 3 highest, zero in → zero out). Instantiate it once for `grant`.
- Everything else lives in one flat module.

## Test plan
- **Single source:** `int_en=4'b1111`; `dev_done[1]` 0→1 → `pending=0010` after the edge, `int_req=1` two edges later, `done2=1`; ack for 3 cycles → `done2` held; release → `pending=0000`, `int_req` back to 0.
- **Priority:** `dev_done` rises `0101` in the same cycle; ack → grant `0100` (`done3`); release → `pending=0001`; request reasserts 2 cycles after CLR; second ack → `done1`.
- **Masking:** `int_en=0000`, `dev_done[3]` rises → `pending=1000`, `int_req` stays 0; write `int_en=1000` → `int_req=1` on the next edge but one.
- **Freeze and collision:**
  - During ACK with grant `0010`, raise `dev_done[3]` → `done` outputs stay `0010`.
  - A rise on `dev_done[1]` in the CLR cycle → `pending[1]` stays 1.
- **Reset mid-ack:** assert `rst` asynchronously during ACK → `int_req`, `done1..done4` and `pending` go to 0 immediately; `int_en=EN_RST`.
- **Spurious ack:** `int_ack=1` in IDLE with `pending=0` → no state change; all outputs 0.
